// File: rtl/lane_compact_packer.sv
// Lane compactor feeding asymmetric_fifo: gathers the masked lanes of each beat in
// ascending lane order and emits only dense N_IN-wide pushes (or padded drain pushes).
module lane_compact_packer #(
    parameter int  N_IN       = 5,
    parameter int  DATA_WIDTH = 8,
    parameter type dtype      = logic [DATA_WIDTH-1:0],
    parameter dtype PAD_VALUE = '0,
    localparam int CNT_W      = $clog2(2*N_IN)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  dtype [N_IN-1:0]     in_data_i,
    input  logic [N_IN-1:0]     in_mask_i,
    input  logic                drain_i,
    output logic                push_o,
    output dtype [N_IN-1:0]     data_o,
    input  logic                full_i,
    output logic [CNT_W-1:0]    level_o
);

    localparam int              DEPTH = 2*N_IN - 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    dtype             buf_q   [DEPTH];
    dtype             buf_nxt [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] wr_pos;

    logic normal_push;
    logic drain_push;
    logic accept;
    logic fire;

    // Handshake and push qualification. Ready looks only at registered count and
    // drain_i, so a full FIFO never reaches back into the input side.
    always_comb begin
        normal_push = (count_q >= N_CNT);
        drain_push  = drain_i && (count_q != '0) && (count_q < N_CNT);
        push_o      = !rst_i && (normal_push || drain_push);
        in_ready_o  = !rst_i && !drain_i && (count_q <= N_CNT - ONE);
        accept      = in_valid_i && in_ready_o;
        fire        = push_o && !full_i;
    end

    // A partial group is padded above the last buffered element.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            if (normal_push || (CNT_W'(i) < count_q)) begin
                data_o[i] = buf_q[i];
            end else begin
                data_o[i] = PAD_VALUE;
            end
        end
    end

    // Shift out a fired group first, then append the accepted lanes behind
    // whatever remains.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        buf_nxt   = buf_q;
        count_nxt = count_q;

        if (fire && normal_push) begin
            for (int j = 0; j < DEPTH - N_IN; j++) begin
                buf_nxt[j] = buf_q[j + N_IN];
            end
            count_nxt = count_q - N_CNT;
        end else if (fire) begin
            count_nxt = '0;
        end

        wr_pos = count_nxt;
        if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_mask_i[i]) begin
                    if (int'(wr_pos) < DEPTH) begin
                        buf_nxt[wr_pos] = in_data_i[i];
                    end
                    wr_pos = wr_pos + ONE;
                end
            end
        end
        count_nxt = wr_pos;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    // NOTE: the element buffer carries no reset; count alone says which slots
    // hold live data, so clearing the storage would only cost logic.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_nxt;
    end

    assign level_o = count_q;

endmodule

// File: tb/tb_lane_compact_packer.sv
// Scoreboard bench for lane_compact_packer (N_IN=5, DATA_WIDTH=8, PAD_VALUE=8'hFF).
module tb_lane_compact_packer;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [4:0][7:0] in_data_i;
    logic [4:0]      in_mask_i;
    logic            drain_i;
    logic            push_o;
    logic [4:0][7:0] data_o;
    logic            full_i;
    logic [3:0]      level_o;

    int errors = 0;
    int checks = 0;

    logic [39:0] exp_q  [$];
    logic [7:0]  elem_q [$];

    lane_compact_packer #(
        .N_IN      (5),
        .DATA_WIDTH(8),
        .PAD_VALUE (8'hFF)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_data_i (in_data_i),
        .in_mask_i (in_mask_i),
        .drain_i   (drain_i),
        .push_o    (push_o),
        .data_o    (data_o),
        .full_i    (full_i),
        .level_o   (level_o)
    );

    always #5 clk = ~clk;

    // Fired pushes are compared against the scoreboard; the counter bound is
    // watched every cycle.
    always @(negedge clk) begin
        if (!rst_i && push_o && !full_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push got=%h exp=none", data_o);
            end else begin
                if (data_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL push_data got=%h exp=%h", data_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (!rst_i && level_o > 4'd9) begin
            checks++;
            errors++;
            $display("FAIL level_bound got=%0d exp<=9", level_o);
        end
    end

    function automatic logic [39:0] mk(input int base);
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(base + i);
        return r;
    endfunction

    task automatic model_append(input logic [39:0] data, input logic [4:0] mask);
        logic [39:0] g;
        for (int i = 0; i < 5; i++) if (mask[i]) elem_q.push_back(data[i*8 +: 8]);
        while (elem_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) g[i*8 +: 8] = elem_q.pop_front();
            exp_q.push_back(g);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_beat(input logic [39:0] data, input logic [4:0] mask);
        int waited = 0;
        in_valid_i = 1'b1;
        in_data_i  = data;
        in_mask_i  = mask;
        @(negedge clk);
        while (!in_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=ready0 exp=ready1");
        end else begin
            model_append(data, mask);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int waited = 0;
        while ((exp_q.size() != 0 || push_o) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0 || push_o) begin
            errors++;
            $display("FAIL %s_idle_timeout got=pending%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic check_level(input string name, input logic [3:0] exp);
        checks++;
        if (level_o !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, level_o, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0;
        drain_i = 1'b0; full_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("reset_push", push_o, 1'b0);
        check_bit("reset_ready", in_ready_o, 1'b0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_bit("post_reset_ready", in_ready_o, 1'b1);
        check_bit("post_reset_push", push_o, 1'b0);
        check_level("post_reset_level", 4'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_dense();
        send_beat(mk(0), 5'b11111);
        check_bit("dense_latency_push", push_o, 1'b1);
        check_level("dense_level_after_beat", 4'd5);
        send_beat(mk(5), 5'b11111);
        send_beat(mk(10), 5'b11111);
        wait_idle("dense");
        check_level("dense_final_level", 4'd0);
    endtask

    task automatic test_sparse();
        send_beat(mk(10), 5'b10101);
        check_level("sparse_level_3", 4'd3);
        check_bit("sparse_no_push", push_o, 1'b0);
        send_beat(mk(20), 5'b01011);
        check_level("sparse_level_6", 4'd6);
        @(posedge clk); #1;
        check_level("sparse_leftover", 4'd1);
        wait_idle("sparse");
    endtask

    task automatic test_backpressure();
        logic [39:0] cap;
        full_i = 1'b1;
        send_beat(mk(30), 5'b00111);
        check_level("bp_level_4", 4'd4);
        send_beat(mk(60), 5'b11111);
        @(negedge clk);
        check_bit("bp_push_high", push_o, 1'b1);
        check_bit("bp_ready_low", in_ready_o, 1'b0);
        check_level("bp_level_9", 4'd9);
        cap = data_o;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (data_o !== cap || push_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable got=%h/%b exp=%h/1", data_o, push_o, cap);
            end
        end
        @(posedge clk); #1;
        full_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        check_level("bp_level_after_fire", 4'd4);
        check_bit("bp_ready_rises", in_ready_o, 1'b1);
    endtask

    task automatic test_fire_then_accept();
        // Level is 4 here; three more lanes make 7.
        send_beat(mk(70), 5'b00111);
        check_level("fa_level_7", 4'd7);
        @(posedge clk); #1;
        check_level("fa_level_2", 4'd2);
        send_beat(mk(80), 5'b00111);
        check_level("fa_level_5", 4'd5);
        wait_idle("fire_accept");
        check_level("fa_final_level", 4'd0);
    endtask

    task automatic test_drain();
        drain_i = 1'b1;
        @(negedge clk);
        check_bit("drain_empty_no_push", push_o, 1'b0);
        @(posedge clk); #1;
        drain_i = 1'b0;
        check_level("drain_empty_level", 4'd0);
        send_beat(mk(40), 5'b00011);
        check_level("drain_level_2", 4'd2);
        drain_i = 1'b1;
        exp_q.push_back({8'hFF, 8'hFF, 8'hFF, 8'd41, 8'd40});
        elem_q.delete();
        @(negedge clk);
        check_bit("drain_push", push_o, 1'b1);
        check_bit("drain_ready_low", in_ready_o, 1'b0);
        @(posedge clk); #1;
        drain_i = 1'b0;
        check_level("drain_level_0", 4'd0);
        wait_idle("drain");
    endtask

    task automatic test_reset_mid_stream();
        full_i = 1'b1;
        send_beat(mk(90), 5'b00001);
        send_beat(mk(95), 5'b11111);
        check_level("rms_level_6", 4'd6);
        rst_i = 1'b1;
        exp_q.delete();
        elem_q.delete();
        @(negedge clk);
        check_bit("rms_push_in_reset", push_o, 1'b0);
        @(posedge clk); #1;
        rst_i  = 1'b0;
        full_i = 1'b0;
        check_level("rms_level_0", 4'd0);
        check_bit("rms_no_push", push_o, 1'b0);
        send_beat(mk(50), 5'b11111);
        wait_idle("reset_mid");
        check_level("rms_final_level", 4'd0);
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse();
        test_backpressure();
        test_fire_then_accept();
        test_drain();
        test_reset_mid_stream();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
